// File: rtl/limbus_sys_acortex_st_to_mm_fifo_pkg.sv
// Shared defaults, register-map addresses and status-word bit positions for the
// Avalon-ST to Avalon-MM read FIFO.
package limbus_sys_acortex_pkg;

  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned DEPTH_DEF       = 128;
  localparam int unsigned FULL_MARGIN_DEF = 3;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int unsigned STAT_LEVEL_LSB     = 0;
  localparam int unsigned STAT_LEVEL_W       = 8;
  localparam int unsigned STAT_EMPTY_BIT     = 8;
  localparam int unsigned STAT_NOT_READY_BIT = 9;
  localparam int unsigned STAT_OVERRUN_BIT   = 31;

endpackage

// File: rtl/limbus_sys_acortex_st_to_mm_fifo_if.sv
// Stream sink plus MM read-slave bundle; the FIFO block is the slave side.
interface limbus_sys_acortex_st_to_mm_fifo_if
  import limbus_sys_acortex_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] avalonst_sink_data;
  logic              avalonst_sink_valid;
  logic              avalonst_sink_ready;

  logic              avalonmm_read_slave_address;
  logic              avalonmm_read_slave_read;
  logic              avalonmm_read_slave_waitrequest;
  logic [DATA_W-1:0] avalonmm_read_slave_readdata;
  logic              avalonmm_read_slave_readdatavalid;

  modport slave (
    input  avalonst_sink_data,
    input  avalonst_sink_valid,
    output avalonst_sink_ready,
    input  avalonmm_read_slave_address,
    input  avalonmm_read_slave_read,
    output avalonmm_read_slave_waitrequest,
    output avalonmm_read_slave_readdata,
    output avalonmm_read_slave_readdatavalid
  );

  modport master (
    output avalonst_sink_data,
    output avalonst_sink_valid,
    input  avalonst_sink_ready,
    output avalonmm_read_slave_address,
    output avalonmm_read_slave_read,
    input  avalonmm_read_slave_waitrequest,
    input  avalonmm_read_slave_readdata,
    input  avalonmm_read_slave_readdatavalid
  );

endinterface

// File: rtl/limbus_sys_acortex_st_to_mm_fifo_sc_fifo.sv
// Single-clock FIFO with a registered read port and an occupancy level output.
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module limbus_sys_acortex_sc_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 128,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned LVL_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_en, rd_en;

  always_comb begin
    rd_en    = pop && (level_q != '0);
    wr_en    = push && ((level_q != LVL_W'(DEPTH)) || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = rdata_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      rdata_d  = mem_q[rd_ptr_q];
    end
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    rdata = rdata_q;
    level = level_q;
  end

endmodule

// File: rtl/limbus_sys_acortex_st_to_mm_fifo.sv
// Avalon-ST sink to Avalon-MM read-slave FIFO with byte reversal on capture.
// Define ACORTEX_ST2MM_STATUS_EN to build the status port with sticky overrun.
module limbus_sys_acortex_st_to_mm_fifo
  import limbus_sys_acortex_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned FULL_MARGIN = FULL_MARGIN_DEF
) (
  input logic                                 clock,
  input logic                                 reset,
  limbus_sys_acortex_st_to_mm_fifo_if.slave   bus
);

  localparam int unsigned       LVL_W     = $clog2(DEPTH) + 1;
  localparam int unsigned       BYTES     = DATA_W / 8;
  localparam logic [LVL_W-1:0]  READY_MAX = LVL_W'(DEPTH - FULL_MARGIN - 1);

  logic              push, data_rd, status_rd, rd_acc, empty;
  logic [DATA_W-1:0] wdata_swapped, fifo_rdata, status_word;
  logic [LVL_W-1:0]  fifo_level, level_post;
  logic              sink_ready_q, sink_ready_d;
  logic              rvalid_q, rvalid_d;
  logic              sel_status_q, sel_status_d;
  logic [DATA_W-1:0] status_q, status_d;

  limbus_sys_acortex_sc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .wdata (wdata_swapped),
    .pop   (data_rd),
    .rdata (fifo_rdata),
    .level (fifo_level)
  );

  always_comb begin
    empty     = (fifo_level == '0);
    push      = bus.avalonst_sink_valid && sink_ready_q;
    data_rd   = bus.avalonmm_read_slave_read &&
                (bus.avalonmm_read_slave_address == ADDR_DATA) && !empty;
    status_rd = bus.avalonmm_read_slave_read &&
                (bus.avalonmm_read_slave_address == ADDR_STATUS);
    rd_acc    = data_rd || status_rd;

    wdata_swapped = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      wdata_swapped[8*b +: 8] = bus.avalonst_sink_data[8*(BYTES-1-b) +: 8];
    end

    // Ready looks ahead at the level after this cycle's push/pop, so it
    // drops in time for the margin to absorb no further words.
    level_post   = fifo_level + LVL_W'(push) - LVL_W'(data_rd);
    sink_ready_d = (level_post <= READY_MAX);
    rvalid_d     = rd_acc;
    sel_status_d = rd_acc ? status_rd : sel_status_q;
    status_d     = status_rd ? status_word : status_q;
  end

`ifdef ACORTEX_ST2MM_STATUS_EN
  logic overrun_q, overrun_d;

  // The status read returns the pre-clear sticky value; a fresh overrun in the
  // same cycle re-arms it for the next read.
  always_comb begin
    status_word = '0;
    status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
    status_word[STAT_EMPTY_BIT]     = empty;
    status_word[STAT_NOT_READY_BIT] = !sink_ready_q;
    status_word[STAT_OVERRUN_BIT]   = overrun_q;
    overrun_d = (overrun_q && !status_rd) ||
                (bus.avalonst_sink_valid && !sink_ready_q);
  end

  always_ff @(posedge clock) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end
`else
  always_comb begin
    status_word = '0;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sink_ready_q <= 1'b0;
      rvalid_q     <= 1'b0;
      sel_status_q <= 1'b0;
      status_q     <= '0;
    end else begin
      sink_ready_q <= sink_ready_d;
      rvalid_q     <= rvalid_d;
      sel_status_q <= sel_status_d;
      status_q     <= status_d;
    end
  end

  always_comb begin
    bus.avalonst_sink_ready               = sink_ready_q;
    bus.avalonmm_read_slave_waitrequest   = bus.avalonmm_read_slave_read &&
                                            (bus.avalonmm_read_slave_address == ADDR_DATA) &&
                                            empty;
    bus.avalonmm_read_slave_readdatavalid = rvalid_q;
    bus.avalonmm_read_slave_readdata      = sel_status_q ? status_q : fifo_rdata;
  end

endmodule

// File: doc/limbus_sys_acortex_st_to_mm_fifo.md
LIMBUS_SYS_ACORTEX_ST_TO_MM_FIFO -- requirements
Module: limbus_sys_acortex_st_to_mm_fifo

Interface
REQ-001 Parameter DATA_W, default 32: width of the stream and read data.
REQ-002 Parameter DEPTH, default 128: FIFO capacity in words, a power of two.
REQ-003 Parameter FULL_MARGIN, default 3: free-slot reserve below which sink ready deasserts.
REQ-004 clock  in  1  single block clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 avalonst_sink_data  in  DATA_W  stream word from the codec capture path.
REQ-007 avalonst_sink_valid  in  1  sink word present.
REQ-008 avalonst_sink_ready  out  1  block can accept a word this cycle.
REQ-009 avalonmm_read_slave_address  in  1  0 = data port, 1 = status port.
REQ-010 avalonmm_read_slave_read  in  1  read strobe.
REQ-011 avalonmm_read_slave_waitrequest  out  1  read stalled.
REQ-012 avalonmm_read_slave_readdata  out  DATA_W  read result.
REQ-013 avalonmm_read_slave_readdatavalid  out  1  readdata valid this cycle.

Function
REQ-014 Push occurs when sink_valid and sink_ready are both high; the word is byte-reversed before storage (stream [31:24] -> MM [7:0], [23:16] -> [15:8], [15:8] -> [23:16], [7:0] -> [31:24]).
REQ-015 sink_ready = (level <= DEPTH-FULL_MARGIN-1), registered from the post-update level; it is never high while level = DEPTH.
REQ-016 waitrequest = read & (address == 0) & empty; it is combinational and never asserts for address 1.
REQ-017 A data read is accepted when read & address==0 & !waitrequest; it pops one word.
REQ-018 Read latency is fixed at 1: readdatavalid pulses high for exactly one cycle, the cycle after acceptance, with the popped word on readdata.
REQ-019 Back-to-back accepted reads on consecutive cycles return consecutive words on consecutive cycles.
REQ-020 Level is ceil(log2(DEPTH))+1 bits wide and ranges 0..DEPTH.
REQ-021 Same-cycle push and pop leave level unchanged. Pointers wrap modulo DEPTH.
REQ-022 On a same-cycle push and pop with level 0, the read stalls and only the push takes effect; the word becomes readable on the next cycle.
REQ-023 readdata holds its last value when readdatavalid is low.

Reset
REQ-024 While reset is high: level = 0, pointers = 0, sink_ready = 0, readdatavalid = 0, readdata = 0, and the status sticky bit is cleared.
REQ-025 sink_ready rises the first cycle after reset deasserts.
REQ-026 A reset asserted mid-burst discards all stored words and any pending readdatavalid.

Configuration
REQ-027 With ACORTEX_ST2MM_STATUS_EN defined, a read at address 1 is accepted immediately and returns a status word one cycle later, with readdatavalid set.
REQ-028 The status word layout: [7:0] level, [8] empty, [9] !sink_ready, [31] sticky overrun (sink_valid seen while sink_ready low), cleared by that status read.
REQ-029 With ACORTEX_ST2MM_STATUS_EN undefined, an address-1 read is accepted and returns 0 with readdatavalid; no sticky logic is built.

Structure
REQ-030 Package limbus_sys_acortex_pkg holds the DATA_W/DEPTH/FULL_MARGIN defaults, the address constants (ADDR_DATA = 0, ADDR_STATUS = 1) and the status bit-position constants.
REQ-031 Storage and pointers are in sub-module limbus_sys_acortex_sc_fifo, a single-clock FIFO with a registered read port and a level output.
REQ-032 Byte reversal, sink_ready, waitrequest, readdatavalid and status logic are in the top level.

Verification
REQ-033 Push 0x11223344 then read address 0 -> readdatavalid one cycle later with readdata 0x44332211.
REQ-034 Push continuously with no reads -> sink_ready drops after 125 words; level stays 125 and no word is lost or duplicated.
REQ-035 Read address 0 while empty -> waitrequest stays high until a push lands; readdatavalid arrives exactly one cycle after acceptance.
REQ-036 Push and read every cycle for 300 cycles starting at level 1 -> level stays 1 and the data order is preserved across pointer wrap.
REQ-037 With STATUS_EN, drive sink_valid while ready is low, then read address 1 -> bit 31 = 1; a second status read -> bit 31 = 0.
REQ-038 Assert reset for 1 cycle at level 40 during a read burst -> no readdatavalid after reset, level 0, and sink_ready high on the following cycle.
